// File: rtl/sorter_pkg.sv
// Shared helpers for the pipelined bitonic sorter: layer count, key ordering
// and the compare-exchange wiring of each bitonic layer.
package sorter_pkg;

  localparam int MAX_W  = 64;
  localparam int MAX_IW = 8;

  typedef struct packed {
    logic [3:0] p;
    logic [3:0] q;
  } layer_t;

  function automatic int num_layers(input int log_k);
    return log_k * (log_k + 1) / 2;
  endfunction

  // Signed value first, original index as tie-break: distinct tags make this a strict order.
  function automatic logic key_gt(input logic signed [MAX_W-1:0]  a_val,
                                  input logic        [MAX_IW-1:0] a_idx,
                                  input logic signed [MAX_W-1:0]  b_val,
                                  input logic        [MAX_IW-1:0] b_idx);
    return (a_val > b_val) || ((a_val == b_val) && (a_idx > b_idx));
  endfunction

  // Layers are numbered merge stage p outer, substage q = p..0 inner.
  function automatic layer_t layer_coord(input int layer);
    layer_t res;
    int     cnt;
    res = '0;
    cnt = 0;
    for (int p = 0; p < 8; p++) begin
      for (int q = p; q >= 0; q--) begin
        if (cnt == layer) begin
          res.p = 4'(p);
          res.q = 4'(q);
        end
        cnt++;
      end
    end
    return res;
  endfunction

  // Lower lane of exchanger c in a substage with partner distance 2^q.
  function automatic int cas_lo_index(input int q, input int c);
    return ((c >> q) << (q + 1)) | (c & ((1 << q) - 1));
  endfunction

  function automatic int cas_partner(input int q, input int lo);
    return lo + (1 << q);
  endfunction

  function automatic bit cas_desc(input int p, input int lo);
    return ((lo >> (p + 1)) & 1) != 0;
  endfunction

endpackage

// File: rtl/bitonic_cas.sv
// One combinational compare-exchange on {value, index} pairs.
// Ascending puts the smaller key on x; descending puts the larger key on x.
module bitonic_cas
  import sorter_pkg::*;
#(
  parameter int N    = 7,
  parameter int IW   = 3,
  parameter bit DESC = 1'b0
) (
  input  logic signed [N-1:0]  a_val,
  input  logic        [IW-1:0] a_idx,
  input  logic signed [N-1:0]  b_val,
  input  logic        [IW-1:0] b_idx,
  output logic signed [N-1:0]  x_val,
  output logic        [IW-1:0] x_idx,
  output logic signed [N-1:0]  y_val,
  output logic        [IW-1:0] y_idx
);

  logic a_gt_b;
  logic swap;

  assign a_gt_b = key_gt({{(MAX_W-N){a_val[N-1]}}, a_val}, {{(MAX_IW-IW){1'b0}}, a_idx},
                         {{(MAX_W-N){b_val[N-1]}}, b_val}, {{(MAX_IW-IW){1'b0}}, b_idx});
  assign swap   = a_gt_b ^ DESC;

  assign x_val = swap ? b_val : a_val;
  assign x_idx = swap ? b_idx : a_idx;
  assign y_val = swap ? a_val : b_val;
  assign y_idx = swap ? a_idx : b_idx;

endmodule

// File: rtl/pipelined_bitonic_sorter.sv
// Fully pipelined bitonic sorter: input register, then one register bank after
// every compare-exchange layer; the network always sorts ascending.
module pipelined_bitonic_sorter
  import sorter_pkg::*;
#(
  parameter int N     = 7,
  parameter int LOG_K = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_desc,
  input  logic [(1<<LOG_K)*N-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_desc,
  output logic [(1<<LOG_K)*N-1:0] out_data,
  output logic [(1<<LOG_K)*LOG_K-1:0] out_idx
);

  localparam int K = 1 << LOG_K;
  localparam int L = num_layers(LOG_K);

  logic signed [N-1:0]     st_val   [L+1][K];
  logic        [LOG_K-1:0] st_idx   [L+1][K];
  logic                    st_valid [L+1];
  logic                    st_desc  [L+1];

  logic signed [N-1:0]     lay_val  [L][K];
  logic        [LOG_K-1:0] lay_idx  [L][K];

  logic advance;

  assign advance   = !st_valid[L] || out_ready;
  assign in_ready  = advance;
  assign out_valid = st_valid[L];
  assign out_desc  = st_desc[L];

  for (genvar l = 0; l < L; l++) begin : g_layer
    localparam layer_t LC = layer_coord(l);
    for (genvar c = 0; c < K/2; c++) begin : g_cas
      localparam int LO = cas_lo_index(int'(LC.q), c);
      localparam int HI = cas_partner(int'(LC.q), LO);
      bitonic_cas #(
        .N    (N),
        .IW   (LOG_K),
        .DESC (cas_desc(int'(LC.p), LO))
      ) u_cas (
        .a_val (st_val[l][LO]),
        .a_idx (st_idx[l][LO]),
        .b_val (st_val[l][HI]),
        .b_idx (st_idx[l][HI]),
        .x_val (lay_val[l][LO]),
        .x_idx (lay_idx[l][LO]),
        .y_val (lay_val[l][HI]),
        .y_idx (lay_idx[l][HI])
      );
    end
  end

  // Data follows the valid bits unconditionally; bubbles carry stale values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= L; s++) begin
        st_valid[s] <= 1'b0;
        st_desc[s]  <= 1'b0;
        for (int e = 0; e < K; e++) begin
          st_val[s][e] <= '0;
          st_idx[s][e] <= '0;
        end
      end
    end else if (advance) begin
      st_valid[0] <= in_valid;
      st_desc[0]  <= in_desc;
      for (int e = 0; e < K; e++) begin
        st_val[0][e] <= in_data[e*N +: N];
        st_idx[0][e] <= LOG_K'(e);
      end
      for (int s = 1; s <= L; s++) begin
        st_valid[s] <= st_valid[s-1];
        st_desc[s]  <= st_desc[s-1];
        for (int e = 0; e < K; e++) begin
          st_val[s][e] <= lay_val[s-1][e];
          st_idx[s][e] <= lay_idx[s-1][e];
        end
      end
    end
  end

  // Descending is the slot-reversed ascending result.
  always_comb begin
    out_data = '0;
    out_idx  = '0;
    for (int s = 0; s < K; s++) begin
      if (st_desc[L]) begin
        out_data[s*N +: N]         = st_val[L][K-1-s];
        out_idx[s*LOG_K +: LOG_K]  = st_idx[L][K-1-s];
      end else begin
        out_data[s*N +: N]         = st_val[L][s];
        out_idx[s*LOG_K +: LOG_K]  = st_idx[L][s];
      end
    end
  end

endmodule

// File: tb/tb_pipelined_bitonic_sorter.sv
// Scoreboard bench: the driver queues expected results, a forked monitor
// compares every presented output against the queue head.
module tb_pipelined_bitonic_sorter;

  localparam int N     = 7;
  localparam int LOG_K = 3;
  localparam int K     = 1 << LOG_K;
  localparam int L     = LOG_K * (LOG_K + 1) / 2;

  typedef struct {
    logic [K*N-1:0]     d;
    logic [K*LOG_K-1:0] i;
    logic               desc;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_desc;
  logic [K*N-1:0]       in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_desc;
  logic [K*N-1:0]       out_data;
  logic [K*LOG_K-1:0]   out_idx;

  exp_t sb[$];
  int   errors;
  int   checks;
  int   run_len;
  int   max_run;
  bit   rnd_done;

  pipelined_bitonic_sorter #(.N(N), .LOG_K(LOG_K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_desc   (in_desc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_desc  (out_desc),
    .out_data  (out_data),
    .out_idx   (out_idx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: each element's slot is its rank under the (value, index) order.
  function automatic exp_t ref_sort(input logic [K*N-1:0] d, input logic desc);
    exp_t r;
    int   v[K];
    int   rank;
    int   slot;
    r.d = '0;
    r.i = '0;
    r.desc = desc;
    for (int e = 0; e < K; e++) v[e] = int'($signed(d[e*N +: N]));
    for (int e = 0; e < K; e++) begin
      rank = 0;
      for (int f = 0; f < K; f++)
        if (v[f] < v[e] || (v[f] == v[e] && f < e)) rank++;
      slot = desc ? K-1-rank : rank;
      r.d[slot*N +: N]         = d[e*N +: N];
      r.i[slot*LOG_K +: LOG_K] = LOG_K'(e);
    end
    return r;
  endfunction

  function automatic logic [K*N-1:0] pack_vals(input int a[K]);
    logic [K*N-1:0] r;
    r = '0;
    for (int e = 0; e < K; e++) r[e*N +: N] = N'(a[e]);
    return r;
  endfunction

  function automatic logic [K*LOG_K-1:0] pack_idx(input int a[K]);
    logic [K*LOG_K-1:0] r;
    r = '0;
    for (int e = 0; e < K; e++) r[e*LOG_K +: LOG_K] = LOG_K'(a[e]);
    return r;
  endfunction

  function automatic logic [K*N-1:0] rand_data(input bit ties);
    logic [K*N-1:0] r;
    for (int e = 0; e < K; e++)
      r[e*N +: N] = ties ? N'($urandom_range(0, 3)) - N'(2) : N'($urandom);
    return r;
  endfunction

  task automatic check_bit(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0b exp=%0b", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [K*N-1:0] d, input logic desc, input exp_t e);
    bit ok;
    ok = 1'b0;
    in_data  = d;
    in_desc  = desc;
    in_valid = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) check_bit("send_timeout", 1'b0, 1'b1);
  endtask

  task automatic send_rand(input bit ties, input logic desc);
    logic [K*N-1:0] d;
    d = rand_data(ties);
    send(d, desc, ref_sort(d, desc));
  endtask

  task automatic drain();
    for (int c = 0; c < 1000 && sb.size() != 0; c++) begin
      @(posedge clk);
      #1;
    end
    check_int("drain_empty", sb.size(), 0);
  endtask

  initial begin
    int   din[K];
    int   vasc[K];
    int   iasc[K];
    int   vdsc[K];
    int   idsc[K];
    int   cyc;
    int   stale;
    exp_t e;

    errors    = 0;
    checks    = 0;
    run_len   = 0;
    max_run   = 0;
    rnd_done  = 1'b0;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_desc   = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) run_len++;
        else run_len = 0;
        if (run_len > max_run) max_run = run_len;
        if (out_valid) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output data=%h idx=%h", out_data, out_idx);
          end else begin
            checks++;
            if (out_data !== sb[0].d || out_idx !== sb[0].i || out_desc !== sb[0].desc) begin
              errors++;
              $display("FAIL sorted_output got data=%h idx=%h desc=%0b exp data=%h idx=%h desc=%0b",
                       out_data, out_idx, out_desc, sb[0].d, sb[0].i, sb[0].desc);
            end
            if (out_ready) void'(sb.pop_front());
          end
        end
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    check_bit("reset_out_valid", out_valid, 1'b0);
    check_int("reset_out_data", int'(out_data == '0), 1);
    check_int("reset_out_idx", int'(out_idx == '0), 1);
    check_bit("reset_out_desc", out_desc, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("in_ready_after_reset", in_ready, 1'b1);

    // Directed ascending with latency measurement
    din  = '{3, -5, 63, -64, 0, 0, 7, -1};
    vasc = '{-64, -5, -1, 0, 0, 3, 7, 63};
    iasc = '{3, 1, 7, 4, 5, 0, 6, 2};
    vdsc = '{63, 7, 3, 0, 0, -1, -5, -64};
    idsc = '{2, 6, 0, 5, 4, 7, 1, 3};
    e.d = pack_vals(vasc); e.i = pack_idx(iasc); e.desc = 1'b0;
    send(pack_vals(din), 1'b0, e);
    cyc = 0;
    for (int c = 1; c <= 50; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cyc = c;
        break;
      end
    end
    check_int("latency_cycles", cyc, L);
    drain();

    e.d = pack_vals(vdsc); e.i = pack_idx(idsc); e.desc = 1'b1;
    send(pack_vals(din), 1'b1, e);
    drain();

    // All elements equal: order is purely by index
    din  = '{-64, -64, -64, -64, -64, -64, -64, -64};
    iasc = '{0, 1, 2, 3, 4, 5, 6, 7};
    idsc = '{7, 6, 5, 4, 3, 2, 1, 0};
    e.d = pack_vals(din); e.i = pack_idx(iasc); e.desc = 1'b0;
    send(pack_vals(din), 1'b0, e);
    e.i = pack_idx(idsc); e.desc = 1'b1;
    send(pack_vals(din), 1'b1, e);
    drain();

    // Ten back-to-back, alternating modes
    max_run = 0;
    for (int t = 0; t < 10; t++) send_rand(t % 3 == 0, (t % 2) == 1);
    drain();
    check_int("b2b_consecutive_valid", max_run, 10);

    // Three-cycle output stall mid-stream
    fork
      begin
        for (int t = 0; t < 8; t++) send_rand(1'b0, t[0]);
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          #1;
          check_bit("stall_in_ready", in_ready, 1'b0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure and input gaps
    rnd_done = 1'b0;
    fork
      begin
        for (int t = 0; t < 200; t++) begin
          send_rand($urandom_range(0, 2) == 0, 1'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with transactions in flight
    for (int t = 0; t < 4; t++) send_rand(1'b0, t[0]);
    out_ready = 1'b0;
    repeat (L) @(posedge clk);
    #1;
    check_bit("pre_reset_out_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("reset_midflight_out_valid", out_valid, 1'b0);
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check_int("post_reset_stale_outputs", stale, 0);
    send_rand(1'b0, 1'b0);
    send_rand(1'b1, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_bitonic_sorter.md
# pipelined_bitonic_sorter

Parametrised, fully pipelined bitonic sorting network for 2^LOG_K signed N-bit elements, with a valid/ready handshake on both sides and a per-transaction ascending/descending mode. It is the next generation of the team's combinational 8-input two-stage bitonic sorter. It adds:
- pipeline registers after every compare-exchange layer
- backpressure
- original-index tracking (each output carries the input position it came from)
- a deterministic tie-break

It sits between a streaming producer and consumer in the sorting datapath.

## Interface
- N, 7, element width, signed two's complement, N ≥ 2
- LOG_K, 3, log2 of element count K = 2^LOG_K, 1 ≤ LOG_K ≤ 5
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept this cycle
- in_desc  in  1  0 = ascending, 1 = descending, sampled with the transaction
- in_data  in  K*N  element e at bits [e*N +: N]
- out_valid  out  1  sorted result valid
- out_ready  in  1  consumer accepts this cycle
- out_desc  out  1  mode of the transaction being output
- out_data  out  K*N  sorted elements; slot s at [s*N +: N]
- out_idx  out  K*LOG_K  original input index of slot s at [s*LOG_K +: LOG_K]

## Operation
- Each element is tagged at entry with its input index e. All comparisons use the key {value (signed), index (unsigned)}, giving a strict total order.
- Network: standard bitonic sort, L = LOG_K*(LOG_K+1)/2 compare-exchange layers, each with K/2 exchangers. K=8 → 6 layers.
- Ascending result: slot 0 holds the minimum key, so equal values appear with lower original index first.
- Descending result: exactly the slot-reversed ascending result, so equal values appear with higher original index first.
- in_desc travels through the pipeline with its transaction and only selects the final output ordering. Transactions with different modes may be interleaved freely.
- Transfer rule: a transfer occurs on a cycle where valid and ready are both high.
- Stall rule:
  - advance = !out_valid || out_ready.
  - in_ready = advance (combinational; no dependence on in_valid).
  - On advance, every stage shifts by one: stage 0 loads in_data/in_valid, and bubbles propagate.
  - On !advance, all stage registers, including their valid bits, hold.
- Output data/idx/desc are stable while out_valid && !out_ready.
- Invalid stages may contain stale data; out_data, out_idx and out_desc are only meaningful when out_valid=1.

## Timing
- Reset (async assert, release synchronous to clk):
  - all stage valid bits are 0
  - out_valid=0, out_data=0, out_idx=0, out_desc=0
  - in_ready=1 one cycle after release
- Latency: a transaction accepted at edge t appears with out_valid=1 after edge t+L, assuming out_ready=1 throughout.
- Throughput: 1 transaction/cycle with out_ready held high.
- A stall of S cycles adds exactly S cycles of latency to every in-flight transaction. No transaction is lost or duplicated.
- Simultaneous output accept and input accept in the same cycle is legal and required for full throughput.
- Reset mid-operation discards all in-flight transactions; out_valid falls immediately on assertion.
- in_valid held high while in_ready=0: the producer holds its data; the block does not sample it.

## Structure
- Package sorter_pkg holds:
  - localparam function num_layers(LOG_K)
  - the key-compare function (signed value, then unsigned index)
  - the partner/direction computation for bitonic layer (stage p, substage q)
- Sub-module bitonic_cas: one compare-exchange on {value, idx} pairs with a static direction parameter, combinational. Generate loops instantiate K/2 × L copies.
- The top level holds the generate-built layers, the per-stage registers (data, idx, valid, desc), the advance logic, and the output reversal mux.

## Test plan
- Ascending, K=8, N=7, in=[3,-5,63,-64,0,0,7,-1] → out=[-64,-5,-1,0,0,3,7,63], idx=[3,1,7,4,5,0,6,2], out_valid exactly 6 cycles after accept.
- Same data with in_desc=1 → out=[63,7,3,0,0,-1,-5,-64], idx=[2,6,0,5,4,7,1,3].
- Ten back-to-back transactions with alternating desc and out_ready=1 → ten consecutive out_valid cycles, each correctly sorted in its own mode.
- out_ready low for 3 cycles mid-stream → in_ready low in those cycles, outputs held stable, and all transactions delivered in order after release.
- All elements equal to -64 → values unchanged, idx=[0..7] ascending and [7..0] descending.
- rst_n asserted with 4 transactions in flight → out_valid=0 immediately. After release, no stale output appears and a new transaction sorts correctly. Repeat with LOG_K=2 and LOG_K=4, N=16, checking against a random reference model.
